// File: rtl/alu_sequencer_if.sv
// Handshake and ALU operand/result bundle for alu_sequencer.
interface alu_sequencer_if;
    logic       start;
    logic       abort;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_op;
    logic [7:0] alu_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] first_err_idx;

    modport master (
        output start, abort, alu_out,
        input  alu_a, alu_b, alu_op, busy, done, pass, err_count, first_err_idx
    );
    modport slave (
        input  start, abort, alu_out,
        output alu_a, alu_b, alu_op, busy, done, pass, err_count, first_err_idx
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU self-test sequencer: drives a=b=A_START+i, checks registered result.
// Define ALU_SEQ_SUB_PHASE_EN to add a subtract phase after the add phase.
module alu_sequencer #(
    parameter int         N_OPS   = 10,
    parameter logic [7:0] A_START = 8'd0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

    localparam logic [7:0] LAST_I = 8'(N_OPS - 1);
    localparam logic [7:0] N_OPS8 = 8'(N_OPS);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_i, r_a, r_err, r_first;
    logic       r_op, r_pass;
    logic       w_sub, w_last, w_mis, w_clear, w_step, w_to_done;
    logic [7:0] w_exp, w_idx, w_err_nxt;

`ifdef ALU_SEQ_SUB_PHASE_EN
    logic r_phase;
    logic w_to_sub;
    assign w_sub = r_phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_phase <= 1'b0;
        else if (w_clear)  r_phase <= 1'b0;
        else if (w_to_sub) r_phase <= 1'b1;
    end
`else
    assign w_sub = 1'b0;
`endif

    assign w_last    = (r_i == LAST_I);
    assign w_exp     = w_sub ? 8'd0 : 8'(r_a + r_a);
    assign w_mis     = (bus.alu_out != w_exp);
    // Subtract-phase vectors are numbered after the add-phase ones.
    assign w_idx     = w_sub ? 8'(N_OPS8 + r_i) : r_i;
    assign w_err_nxt = (w_mis && r_err != 8'hFF) ? 8'(r_err + 8'd1) : r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_step      = 1'b0;
        w_to_done   = 1'b0;
`ifdef ALU_SEQ_SUB_PHASE_EN
        w_to_sub    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt = S_DRIVE;
                    w_clear     = 1'b1;
                end
            end
            S_DRIVE: w_state_nxt = bus.abort ? S_IDLE : S_CHECK;
            S_CHECK: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_last) begin
                    w_state_nxt = S_DRIVE;
                    w_step      = 1'b1;
`ifdef ALU_SEQ_SUB_PHASE_EN
                end else if (!w_sub) begin
                    w_state_nxt = S_DRIVE;
                    w_to_sub    = 1'b1;
`endif
                end else begin
                    w_state_nxt = S_DONE;
                    w_to_done   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operands are loaded on entry to DRIVE and held through CHECK and IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_i     <= 8'd0;
            r_a     <= 8'd0;
            r_op    <= 1'b0;
            r_err   <= 8'd0;
            r_first <= 8'd0;
            r_pass  <= 1'b0;
        end else if (w_clear) begin
            r_i     <= 8'd0;
            r_a     <= A_START;
            r_op    <= 1'b1;
            r_err   <= 8'd0;
            r_first <= 8'd0;
            r_pass  <= 1'b0;
        end else if (r_state == S_CHECK && !bus.abort) begin
            r_err <= w_err_nxt;
            if (w_mis && r_err == 8'd0) r_first <= w_idx;
            if (w_step) begin
                r_i <= 8'(r_i + 8'd1);
                r_a <= 8'(A_START + r_i + 8'd1);
            end
`ifdef ALU_SEQ_SUB_PHASE_EN
            if (w_to_sub) begin
                r_i  <= 8'd0;
                r_a  <= A_START;
                r_op <= 1'b0;
            end
`endif
            if (w_to_done) r_pass <= (w_err_nxt == 8'd0);
        end
    end

    assign bus.alu_a         = r_a;
    assign bus.alu_b         = r_a;
    assign bus.alu_op        = r_op;
    assign bus.busy          = (r_state == S_DRIVE) || (r_state == S_CHECK);
    assign bus.done          = (r_state == S_DONE);
    assign bus.pass          = r_pass;
    assign bus.err_count     = r_err;
    assign bus.first_err_idx = r_first;
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter N_OPS, default 10, vectors per phase; legal range 1..256.
REQ-002 Parameter A_START, default 0, first operand value of each phase (8-bit).
REQ-003 clk  input  1  sole clock, all state rising-edge.
REQ-004 rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-005 start  input  1  run request, sampled at rising clk edge in IDLE.
REQ-006 abort  input  1  terminate run, sampled at rising clk edge.
REQ-007 alu_a  output  8  operand A driven to ALU.
REQ-008 alu_b  output  8  operand B driven to ALU.
REQ-009 alu_op  output  1  1 = add, 0 = subtract.
REQ-010 alu_out  input  8  ALU result; ALU registers result one clk after operands.
REQ-011 busy  output  1  high from first DRIVE cycle through last CHECK cycle.
REQ-012 done  output  1  one-cycle pulse on run completion.
REQ-013 pass  output  1  1 when completed run had zero mismatches; held until next start.
REQ-014 err_count  output  8  mismatch count, saturating at 255.
REQ-015 first_err_idx  output  8  vector index of first mismatch; 0 if none.

Function
REQ-016 FSM states IDLE, DRIVE, CHECK, DONE; each vector takes one DRIVE plus one CHECK cycle.
REQ-017 IDLE -> DRIVE when start=1; clears err_count, pass, first_err_idx, index i, phase=ADD.
REQ-018 DRIVE: alu_a = alu_b = (A_START + i) mod 256, alu_op = 1 in ADD phase, 0 in SUB phase; DRIVE -> CHECK unconditionally.
REQ-019 Operands remain stable through the following CHECK cycle.
REQ-020 CHECK: compare alu_out with expected; ADD expected = (2*(A_START+i)) mod 256, SUB expected = 0.
REQ-021 Mismatch in CHECK: err_count increments unless 255; first_err_idx captures i (ADD) or N_OPS+i mod 256 (SUB) on first mismatch only.
REQ-022 CHECK -> DRIVE with i+1 if i < N_OPS-1; else phase transition per REQ-031/032.
REQ-023 DONE: done=1 for exactly one cycle, pass = (err_count == 0), then IDLE.
REQ-024 Run latency without abort: done asserts 2*N_OPS*P+1 cycles after start sampled, P = phases (1 or 2).
REQ-025 start while busy is ignored; start in DONE cycle is ignored.
REQ-026 abort in DRIVE or CHECK: next state IDLE, busy=0, done not pulsed, pass=0, err_count/first_err_idx hold.
REQ-027 abort and start in same IDLE cycle: abort wins, stays IDLE.
REQ-028 Operand value wraps modulo 256 (e.g. A_START=250, i=10 -> 4).
REQ-029 In IDLE, alu_a/alu_b/alu_op hold last driven values.

Reset
REQ-030 rst=0 asynchronously forces IDLE and alu_a=0, alu_b=0, alu_op=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, i=0, phase=ADD, including mid-run; no done pulse on release.

Configuration
REQ-031 Macro ALU_SEQ_SUB_PHASE_EN defined: after last ADD vector, phase=SUB, i=0, -> DRIVE; after last SUB vector -> DONE (P=2).
REQ-032 ALU_SEQ_SUB_PHASE_EN undefined: after last ADD vector -> DONE (P=1); no SUB logic present, alu_op stays 1 during runs.

Verification
REQ-033 Correct ALU model, N_OPS=10, A_START=0, macro defined: start pulse -> alu_a=0..9 add then sub, done at cycle 41, pass=1, err_count=0.
REQ-034 Same with macro undefined -> done at cycle 21, alu_op never 0 during run, pass=1.
REQ-035 ALU model forcing result 0xFF when a=3 in add -> err_count=1, first_err_idx=3, pass=0; sub fault at a=5 -> first_err_idx=15 if no earlier error.
REQ-036 A_START=250, N_OPS=10, correct ALU -> operands 250..255,0..3, add expected 244..254,0..6 wrap, pass=1.
REQ-037 abort asserted in CHECK of vector 4 -> IDLE next cycle, busy=0, no done; later start runs fresh full sequence with pass=1.
REQ-038 rst=0 during DRIVE of vector 2 -> all outputs zero immediately; start ignored while busy verified by second start at cycle 5 having no effect.
